// File: rtl/rv_gpio_pkg.sv
// Shared definitions for rv_gpio: register selectors, byte offsets and
// a byte-enable expansion helper.
package rv_gpio_pkg;

    typedef enum logic [2:0] {
        REG_OUT  = 3'd0,
        REG_IN   = 3'd1,
        REG_DIR  = 3'd2,
        REG_IE   = 3'd3,
        REG_STAT = 3'd4,
        REG_RISE = 3'd5,
        REG_FALL = 3'd6,
        REG_TGL  = 3'd7
    } gpio_reg_e;

    localparam logic [4:0] GPIO_OUT  = 5'h00;
    localparam logic [4:0] GPIO_IN   = 5'h04;
    localparam logic [4:0] GPIO_DIR  = 5'h08;
    localparam logic [4:0] GPIO_IE   = 5'h0C;
    localparam logic [4:0] GPIO_STAT = 5'h10;
    localparam logic [4:0] GPIO_RISE = 5'h14;
    localparam logic [4:0] GPIO_FALL = 5'h18;
    localparam logic [4:0] GPIO_TGL  = 5'h1C;

    function automatic logic [31:0] byte_mask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/rv_sync.sv
// Multi-bit N-stage synchroniser for asynchronous inputs; reset clears
// every stage.
module rv_sync #(
    parameter int unsigned W      = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] ff_q [STAGES];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                ff_q[i] <= '0;
            end
        end else begin
            ff_q[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) begin
                ff_q[i] <= ff_q[i-1];
            end
        end
    end

    assign q = ff_q[STAGES-1];

endmodule

// File: rtl/rv_gpio.sv
// Memory-mapped GPIO: per-pin direction, toggle, synchronised inputs and
// rising/falling edge capture into a write-1-to-clear status register.
module rv_gpio
    import rv_gpio_pkg::*;
#(
    parameter int unsigned         WIDTH       = 8,
    parameter int unsigned         SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0]    RST_OUT     = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       adr,
    input  logic             cs,
    input  logic             rdy,
    input  logic [3:0]       we,
    input  logic             re,
    input  logic [31:0]      dw,
    output logic [31:0]      dr,
    output logic             irq,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] pout,
    output logic [WIDTH-1:0] poe
);

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] ie_q, ie_d;
    logic [WIDTH-1:0] stat_q, stat_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] p_q;
    logic [31:0]      dr_q, dr_d;

    logic             wr_en, rd_en;
    gpio_reg_e        sel;
    logic [31:0]      mask32;
    logic [WIDTH-1:0] m, wdat, clr, s, rise, fall;
    logic [31:0]      rdata;
    logic             unused_bits;

    assign wr_en  = cs & rdy & (we != 4'b0000);
    assign rd_en  = cs & rdy & re;
    assign sel    = gpio_reg_e'(adr[4:2]);
    assign mask32 = byte_mask(we);
    assign m      = mask32[WIDTH-1:0];
    assign wdat   = dw[WIDTH-1:0];
    assign unused_bits = ^{adr[1:0], dw, mask32};

    rv_sync #(
        .W      (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pin),
        .q     (s)
    );

    assign rise = s & ~p_q;
    assign fall = ~s & p_q;
    assign clr  = (wr_en && sel == REG_STAT) ? (wdat & m) : '0;

    always_comb begin
        out_d  = out_q;
        dir_d  = dir_q;
        ie_d   = ie_q;
        rise_d = rise_q;
        fall_d = fall_q;
        // set terms OR'd after the clear so a same-cycle edge wins
        stat_d = (stat_q & ~clr) | (rise & rise_q) | (fall & fall_q);
        if (wr_en) begin
            unique case (sel)
                REG_OUT:  out_d  = (out_q  & ~m) | (wdat & m);
                REG_DIR:  dir_d  = (dir_q  & ~m) | (wdat & m);
                REG_IE:   ie_d   = (ie_q   & ~m) | (wdat & m);
                REG_RISE: rise_d = (rise_q & ~m) | (wdat & m);
                REG_FALL: fall_d = (fall_q & ~m) | (wdat & m);
                REG_TGL:  out_d  = out_q ^ (wdat & m);
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        unique case (sel)
            REG_OUT:  rdata = 32'(out_q);
            REG_IN:   rdata = 32'(s);
            REG_DIR:  rdata = 32'(dir_q);
            REG_IE:   rdata = 32'(ie_q);
            REG_STAT: rdata = 32'(stat_q);
            REG_RISE: rdata = 32'(rise_q);
            REG_FALL: rdata = 32'(fall_q);
            REG_TGL:  rdata = '0;
            default:  rdata = '0;
        endcase
        dr_d = rd_en ? rdata : dr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q  <= RST_OUT;
            dir_q  <= '0;
            ie_q   <= '0;
            stat_q <= '0;
            rise_q <= '0;
            fall_q <= '0;
            p_q    <= '0;
            dr_q   <= '0;
        end else begin
            out_q  <= out_d;
            dir_q  <= dir_d;
            ie_q   <= ie_d;
            stat_q <= stat_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            p_q    <= s;
            dr_q   <= dr_d;
        end
    end

    assign dr   = dr_q;
    assign pout = out_q;
    assign poe  = dir_q;
    assign irq  = |(stat_q & ie_q);

endmodule
